data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Core-side data memory bus: one access per cycle, no handshake.
// The core drives address/data/type/direction; the responder returns load data and the fault flag.
interface data_mem_responder_if #(
  parameter int size = 32
);
  logic [size-1:0] RAM_Addr_i;
  logic [size-1:0] RAM_DATA_i;
  logic [2:0]      RAM_DATA_control;
  logic            RAM_rw;
  logic [size-1:0] MEM_result_o;
  logic            mem_fault_o;

  modport master (
    output RAM_Addr_i, RAM_DATA_i, RAM_DATA_control, RAM_rw,
    input  MEM_result_o, mem_fault_o
  );

  modport slave (
    input  RAM_Addr_i, RAM_DATA_i, RAM_DATA_control, RAM_rw,
    output MEM_result_o, mem_fault_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port data RAM for the core MEM stage: combinational loads, byte-enabled stores on the
// clock edge, plus a small MMIO block with a store counter and a sticky misaligned-store fault.
module data_mem_responder #(
  parameter int size        = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input logic                clk,
  input logic                reset,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {
    ACC_B  = 3'b000,
    ACC_H  = 3'b001,
    ACC_W  = 3'b010,
    ACC_BU = 3'b100,
    ACC_HU = 3'b101
  } access_e;

  typedef enum logic [5:0] {
    REG_COUNT  = 6'd0,
    REG_FAULT  = 6'd1,
    REG_FADDR  = 6'd2,
    REG_DEPTH  = 6'd3
  } mmio_reg_e;

  logic [size-1:0] ram [DEPTH_WORDS];

  logic [size-1:0] store_count;
  logic            fault;
  logic [size-1:0] fault_addr;

  logic [AW-1:0]   word_idx;
  logic [size-1:0] rd_word;
  logic            is_mmio;
  logic [5:0]      mmio_word;
  logic [1:0]      lane;

  assign word_idx  = bus.RAM_Addr_i[AW+1:2];
  assign rd_word   = ram[word_idx];
  assign is_mmio   = &bus.RAM_Addr_i[size-1:8];
  assign mmio_word = bus.RAM_Addr_i[7:2];
  assign lane      = bus.RAM_Addr_i[1:0];

  // ---------------------------------------------------------------- load path
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [size-1:0] ram_rd;
  logic [size-1:0] mmio_rd;

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    ld_byte = rd_word[7:0];
    case (lane)
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      2'd3:    ld_byte = rd_word[31:24];
      default: ld_byte = rd_word[7:0];
    endcase
    ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    ram_rd = '0;
    case (bus.RAM_DATA_control)
      ACC_B:   ram_rd = {{24{ld_byte[7]}}, ld_byte};
      ACC_H:   ram_rd = {{16{ld_half[15]}}, ld_half};
      ACC_W:   ram_rd = rd_word;
      ACC_BU:  ram_rd = {24'd0, ld_byte};
      ACC_HU:  ram_rd = {16'd0, ld_half};
      default: ram_rd = '0;
    endcase
  end

  // MMIO registers are word-only and must be aligned; anything else reads as zero.
  always_comb begin
    mmio_rd = '0;
    if (bus.RAM_DATA_control == ACC_W && lane == 2'd0) begin
      case (mmio_word)
        REG_COUNT: mmio_rd = store_count;
        REG_FAULT: mmio_rd = {{(size-1){1'b0}}, fault};
        REG_FADDR: mmio_rd = fault_addr;
        REG_DEPTH: mmio_rd = size'(DEPTH_WORDS);
        default:   mmio_rd = '0;
      endcase
    end
  end

  assign bus.MEM_result_o = is_mmio ? mmio_rd : ram_rd;
  assign bus.mem_fault_o  = fault;

  // --------------------------------------------------------------- store path
  logic            store_fault;
  logic [3:0]      byte_en;
  logic [size-1:0] wdata;

  always_comb begin
    store_fault = 1'b0;
    byte_en     = 4'b0000;
    wdata       = bus.RAM_DATA_i;
    case (bus.RAM_DATA_control)
      ACC_B: begin
        byte_en = 4'b0001 << lane;
        wdata   = {4{bus.RAM_DATA_i[7:0]}};
      end
      ACC_H: begin
        store_fault = lane[0];
        byte_en     = 4'b0011 << {lane[1], 1'b0};
        wdata       = {2{bus.RAM_DATA_i[15:0]}};
      end
      ACC_W: begin
        store_fault = (lane != 2'd0);
        byte_en     = 4'b1111;
      end
      default: store_fault = 1'b1;
    endcase
    store_fault = store_fault & bus.RAM_rw;
  end

  logic ram_we;
  logic mmio_w_store;
  logic clear_fault_req;
  logic clear_count;

  assign ram_we       = bus.RAM_rw && !reset && !store_fault && !is_mmio;
  assign mmio_w_store = bus.RAM_rw && is_mmio && bus.RAM_DATA_control == ACC_W;
  // The fault-clear register is decoded by word so a misaligned clear still counts as a clear;
  // that is what lets a new fault and a clear land in the same cycle.
  assign clear_fault_req = mmio_w_store && mmio_word == REG_FAULT && bus.RAM_DATA_i[0];
  assign clear_count     = mmio_w_store && mmio_word == REG_COUNT && !store_fault;

  // NOTE: the RAM array has no reset; its contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) ram[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_count <= '0;
      fault       <= 1'b0;
      fault_addr  <= '0;
    end else begin
      if (clear_count) begin
        store_count <= '0;
      end else if (ram_we && store_count != '1) begin
        store_count <= store_count + 1'b1;
      end

      // A new fault beats a simultaneous clear and is then treated as the first fault.
      if (store_fault) begin
        fault <= 1'b1;
        if (!fault || clear_fault_req) fault_addr <= bus.RAM_Addr_i;
      end else if (clear_fault_req) begin
        fault <= 1'b0;
      end
    end
  end

endmodule
